// File: rtl/linear_flash_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for the 8-bit asynchronous linear flash bus.
// Build option: define LINEAR_FLASH_WR_EN to enable flash writes; otherwise writes complete without strobing.
module linear_flash_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 4,
  parameter int WR_WAIT = 4,
  parameter int TURN    = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] Linear_Flash_address,
  output logic              Linear_Flash_ce_n,
  output logic              Linear_Flash_oe_n,
  output logic              Linear_Flash_we_n,
  output logic [DATA_W-1:0] Linear_Flash_data_o,
  output logic              Linear_Flash_data_oe,
  input  logic [DATA_W-1:0] Linear_Flash_data_i
);

`ifdef LINEAR_FLASH_WR_EN
  localparam bit C_WR_EN = 1'b1;
`else
  localparam bit C_WR_EN = 1'b0;
`endif

  localparam logic [7:0] RD_CNT   = 8'(RD_WAIT);
  localparam logic [7:0] WR_CNT   = 8'(WR_WAIT);
  localparam logic [7:0] TURN_CNT = 8'(TURN);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURNAROUND
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic                r_sel;        // 0 = port A, 1 = port B
  logic                r_we;
  logic                r_last_b;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_a_ack;
  logic                r_b_ack;
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;
  logic                r_busy;

  logic                w_grant;
  logic                w_grant_b;
  logic                w_cap_rd;
  logic                w_sel_nxt;
  logic                w_we_nxt;
  logic                w_active_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_grant_b   = 1'b0;
    w_cap_rd    = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req && (!b_req || r_last_b)) begin
          w_grant     = 1'b1;
          w_state_nxt = SETUP;
        end else if (b_req) begin
          w_grant     = 1'b1;
          w_grant_b   = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (r_we && !C_WR_EN) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = r_we ? WR_CNT : RD_CNT;
        end
      end
      STROBE: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = HOLD;
          w_cap_rd    = !r_we;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      HOLD: begin
        if (TURN == 0) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = TURNAROUND;
          w_cnt_nxt   = TURN_CNT;
        end
      end
      TURNAROUND: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    w_sel_nxt    = w_grant ? w_grant_b : r_sel;
    w_we_nxt     = w_grant ? (w_grant_b ? b_we : a_we) : r_we;
    w_active_nxt = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) ||
                   (w_state_nxt == HOLD);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      r_last_b  <= 1'b1;
      r_addr    <= '0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_sel  <= w_grant_b;
        r_we   <= w_we_nxt;
        r_addr <= w_grant_b ? b_addr : a_addr;
      end
      if (r_state == HOLD) begin
        r_last_b <= r_sel;
      end
      if (w_cap_rd) begin
        if (r_sel) begin
          r_b_rdata <= Linear_Flash_data_i;
        end else begin
          r_a_rdata <= Linear_Flash_data_i;
        end
      end
      r_ce_n  <= !w_active_nxt;
      r_oe_n  <= !((w_state_nxt == STROBE) && !w_we_nxt);
      r_a_ack <= (w_state_nxt == HOLD) && !w_sel_nxt;
      r_b_ack <= (w_state_nxt == HOLD) && w_sel_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

`ifdef LINEAR_FLASH_WR_EN
  logic              r_we_n;
  logic              r_data_oe;
  logic [DATA_W-1:0] r_data_o;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_we_n    <= 1'b1;
      r_data_oe <= 1'b0;
      r_data_o  <= '0;
    end else begin
      r_we_n    <= !((w_state_nxt == STROBE) && w_we_nxt);
      r_data_oe <= w_active_nxt && w_we_nxt;
      if (w_grant && w_we_nxt) begin
        r_data_o <= w_grant_b ? b_wdata : a_wdata;
      end
    end
  end

  assign Linear_Flash_we_n    = r_we_n;
  assign Linear_Flash_data_oe = r_data_oe;
  assign Linear_Flash_data_o  = r_data_o;
`else
  logic w_unused_wdata;
  assign w_unused_wdata       = ^{a_wdata, b_wdata};
  assign Linear_Flash_we_n    = 1'b1;
  assign Linear_Flash_data_oe = 1'b0;
  assign Linear_Flash_data_o  = '0;
`endif

  assign a_ack                = r_a_ack;
  assign b_ack                = r_b_ack;
  assign a_rdata              = r_a_rdata;
  assign b_rdata              = r_b_rdata;
  assign busy                 = r_busy;
  assign Linear_Flash_address = r_addr;
  assign Linear_Flash_ce_n    = r_ce_n;
  assign Linear_Flash_oe_n    = r_oe_n;

endmodule

// File: tb/tb_linear_flash_arbiter.sv
// Directed bench for linear_flash_arbiter: read/write timing, round-robin, reset abort, strobe exclusivity.
module tb_linear_flash_arbiter;

  logic        CLOCK;
  logic        RESET;

  // Main DUT: RD_WAIT=4, WR_WAIT=3, TURN=1
  logic        a_req, a_we, b_req, b_we;
  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack, busy;
  logic [7:0]  a_rdata, b_rdata;
  logic [18:0] fl_addr;
  logic        fl_ce_n, fl_oe_n, fl_we_n, fl_data_oe;
  logic [7:0]  fl_data_o, fl_data_i;
  logic [7:0]  flash_val;

  // Second DUT: RD_WAIT=4, TURN=0, both ports streaming reads
  logic        z_a_req, z_b_req;
  logic [18:0] z_a_addr, z_b_addr;
  logic        z_a_ack, z_b_ack, z_busy;
  logic [7:0]  z_a_rdata, z_b_rdata;
  logic [18:0] z_addr;
  logic        z_ce_n, z_oe_n, z_we_n, z_data_oe;
  logic [7:0]  z_data_o, z_data_i;

  int n_checks;
  int n_fail;
  int n_viol;

  assign fl_data_i = fl_oe_n ? 8'h00 : flash_val;
  assign z_data_i  = z_oe_n ? 8'h00 : z_addr[7:0];

  linear_flash_arbiter #(.ADDR_W(19), .DATA_W(8), .RD_WAIT(4), .WR_WAIT(3), .TURN(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy),
    .Linear_Flash_address(fl_addr), .Linear_Flash_ce_n(fl_ce_n),
    .Linear_Flash_oe_n(fl_oe_n), .Linear_Flash_we_n(fl_we_n),
    .Linear_Flash_data_o(fl_data_o), .Linear_Flash_data_oe(fl_data_oe),
    .Linear_Flash_data_i(fl_data_i)
  );

  linear_flash_arbiter #(.ADDR_W(19), .DATA_W(8), .RD_WAIT(4), .WR_WAIT(4), .TURN(0)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET),
    .a_req(z_a_req), .a_we(1'b0), .a_addr(z_a_addr), .a_wdata(8'h00),
    .a_ack(z_a_ack), .a_rdata(z_a_rdata),
    .b_req(z_b_req), .b_we(1'b0), .b_addr(z_b_addr), .b_wdata(8'h00),
    .b_ack(z_b_ack), .b_rdata(z_b_rdata),
    .busy(z_busy),
    .Linear_Flash_address(z_addr), .Linear_Flash_ce_n(z_ce_n),
    .Linear_Flash_oe_n(z_oe_n), .Linear_Flash_we_n(z_we_n),
    .Linear_Flash_data_o(z_data_o), .Linear_Flash_data_oe(z_data_oe),
    .Linear_Flash_data_i(z_data_i)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Strobe exclusivity on both instances, sampled mid-cycle
  always @(negedge CLOCK) begin
    if (!RESET) begin
      if ((!fl_oe_n && fl_data_oe) || (!fl_oe_n && !fl_we_n) ||
          (!z_oe_n && z_data_oe) || (!z_oe_n && !z_we_n))
        n_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  int          lg_oe_low, lg_we_low, lg_doe, lg_ack_cyc, lg_ack_n, lg_other_ack;
  logic [7:0]  lg_rdata, lg_pad, lg_dout_or;
  logic [18:0] lg_addr1;
  logic        lg_ce[0:15];
  logic        lg_busy[0:15];

  // One access on the main DUT; cycle 1 is the first observation after the grant edge.
  task automatic run_access(input bit port_b, input bit we, input logic [18:0] addr,
                            input logic [7:0] wdata);
    lg_oe_low = 0; lg_we_low = 0; lg_doe = 0; lg_ack_cyc = -1; lg_ack_n = 0;
    lg_other_ack = 0; lg_rdata = '0; lg_pad = '0; lg_dout_or = '0; lg_addr1 = '0;
    if (port_b) begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      lg_ce[c]   = fl_ce_n;
      lg_busy[c] = busy;
      if (c == 1) lg_addr1 = fl_addr;
      if (!fl_oe_n) lg_oe_low++;
      if (!fl_we_n) begin lg_we_low++; lg_pad = fl_data_o; end
      if (fl_data_oe) lg_doe++;
      lg_dout_or = lg_dout_or | fl_data_o;
      if (port_b ? a_ack : b_ack) lg_other_ack++;
      if (port_b ? b_ack : a_ack) begin
        lg_ack_n++;
        if (lg_ack_cyc < 0) begin
          lg_ack_cyc = c;
          lg_rdata   = port_b ? b_rdata : a_rdata;
        end
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  int          z_nacks;
  int          z_ack_t[0:7];
  logic [7:0]  z_seq;
  logic        z_log_busy[0:31];
  logic        z_log_ce[0:31];
  int          exp_wack, exp_wlow, exp_doe;
  logic        rs_ack_seen;

  initial begin
    n_checks = 0; n_fail = 0; n_viol = 0;
    RESET = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    z_a_req = 0; z_b_req = 0; z_a_addr = 19'h00033; z_b_addr = 19'h00044;
    flash_val = 8'h00;
    z_nacks = 0; z_seq = '0;
`ifdef LINEAR_FLASH_WR_EN
    exp_wack = 5; exp_wlow = 3; exp_doe = 5;
`else
    exp_wack = 2; exp_wlow = 0; exp_doe = 0;
`endif

    repeat (2) tick();
    check("rst_strobes", {29'd0, fl_ce_n, fl_oe_n, fl_we_n}, 32'h7);
    check("rst_doe", fl_data_oe, 0);
    check("rst_addr", fl_addr, 0);
    check("rst_data_o", fl_data_o, 0);
    check("rst_busy_ack", {busy, a_ack, b_ack}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);

    // Contention from reset on the TURN=0 instance
    z_a_req = 1'b1; z_b_req = 1'b1;
    RESET = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      z_log_busy[t] = z_busy;
      z_log_ce[t]   = z_ce_n;
      if (z_a_ack || z_b_ack) begin
        if (z_nacks < 8) begin
          z_seq[z_nacks]   = z_b_ack;
          z_ack_t[z_nacks] = t;
        end
        z_nacks++;
      end
    end
    z_a_req = 1'b0; z_b_req = 1'b0;
    check("arb_nacks", z_nacks, 4);
    check("arb_order", {28'd0, z_seq[3:0]}, 32'hA);
    check("arb_first_ack", z_ack_t[0], 6);
    check("arb_period", z_ack_t[3] - z_ack_t[0], 21);
    check("t0_idle_after_hold", z_log_busy[7], 0);
    check("t0_setup_next", {z_log_ce[8], z_log_busy[8]}, 32'h1);
    check("arb_rdata", {z_a_rdata, z_b_rdata}, 32'h3344);
    repeat (10) tick();

    // Single read, port A
    flash_val = 8'hA5;
    run_access(1'b0, 1'b0, 19'h12345, 8'h00);
    check("rd_addr", lg_addr1, 32'h12345);
    check("rd_oe_low", lg_oe_low, 4);
    check("rd_ack_cyc", lg_ack_cyc, 6);
    check("rd_ack_n", lg_ack_n, 1);
    check("rd_rdata", lg_rdata, 32'hA5);
    check("rd_turn", {lg_ce[7], lg_busy[7]}, 32'h3);
    check("rd_idle", lg_busy[8], 0);

    // Read on B so that a later B write can show rdata is untouched
    flash_val = 8'h5C;
    run_access(1'b1, 1'b0, 19'h00200, 8'h00);
    check("rdb_rdata", lg_rdata, 32'h5C);
    check("rdb_a_quiet", lg_other_ack, 0);

    // Single write, port B
    flash_val = 8'hEE;
    run_access(1'b1, 1'b1, 19'h7FFFF, 8'h3C);
    check("wrb_addr", lg_addr1, 32'h7FFFF);
    check("wrb_ack_cyc", lg_ack_cyc, exp_wack);
    check("wrb_ack_n", lg_ack_n, 1);
    check("wrb_we_low", lg_we_low, exp_wlow);
    check("wrb_doe", lg_doe, exp_doe);
    check("wrb_oe_low", lg_oe_low, 0);
    check("wrb_rdata_held", b_rdata, 32'h5C);
`ifdef LINEAR_FLASH_WR_EN
    check("wrb_pad", lg_pad, 32'h3C);
`else
    check("wrb_pad_tied", lg_dout_or, 0);
`endif

    // Single write, port A
    run_access(1'b0, 1'b1, 19'h00001, 8'h5A);
    check("wra_ack_cyc", lg_ack_cyc, exp_wack);
    check("wra_we_low", lg_we_low, exp_wlow);
    check("wra_rdata_held", a_rdata, 32'hA5);
`ifdef LINEAR_FLASH_WR_EN
    check("wra_pad", lg_pad, 32'h5A);
`else
    check("wra_doe_tied", lg_doe, 0);
`endif

    // Reset during STROBE of a read
    flash_val = 8'h77;
    a_we = 1'b0; a_addr = 19'h00100; a_req = 1'b1;
    repeat (3) tick();
    check("rs_oe_pre", fl_oe_n, 0);
    RESET = 1'b1;
    #1;
    check("rs_strobes", {30'd0, fl_ce_n, fl_oe_n}, 32'h3);
    check("rs_busy", busy, 0);
    a_req = 1'b0;
    rs_ack_seen = a_ack;
    repeat (2) begin
      tick();
      rs_ack_seen = rs_ack_seen | a_ack;
    end
    RESET = 1'b0;
    tick();
    rs_ack_seen = rs_ack_seen | a_ack;
    check("rs_no_ack", rs_ack_seen, 0);
    check("rs_rdata_clr", a_rdata, 0);
    run_access(1'b0, 1'b0, 19'h00100, 8'h00);
    check("rs_reissue_ack", lg_ack_cyc, 6);
    check("rs_reissue_rdata", lg_rdata, 32'h77);

    check("strobe_overlap", n_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_flash_arbiter.md
# linear_flash_arbiter

Sequencer and two-port arbiter for the 8-bit asynchronous parallel (linear) flash bus in the SPI bootloader system. It shares the flash between two requesters, port A (processor bus bridge) and port B (boot-image copy engine), with round-robin arbitration. For each granted access it generates correctly timed chip-enable, output-enable and write-enable strobes with programmable wait states. The data pin tristate buffer sits at the top level; this block drives its output, enable and input sides.

## Interface
Parameters:
- ADDR_W, 19, flash address width
- DATA_W, 8, flash data width
- RD_WAIT, 4, cycles oe_n is held low before read data is sampled (1..255)
- WR_WAIT, 4, we_n low pulse width in cycles (1..255)
- TURN, 1, idle cycles with ce_n high between accesses (0..255)

Ports:
- CLOCK  in  1  system clock, single clock domain
- RESET  in  1  asynchronous, active-high reset
- a_req / b_req  in  1  access request, held until ack
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  access address
- a_wdata / b_wdata  in  DATA_W  write data
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_rdata / b_rdata  out  DATA_W  read data, valid while ack is high; held until next ack on that port
- busy  out  1  high in any state other than IDLE
- Linear_Flash_address  out  ADDR_W  flash address
- Linear_Flash_ce_n / _oe_n / _we_n  out  1  flash strobes, active low
- Linear_Flash_data_o  out  DATA_W  data to pad
- Linear_Flash_data_oe  out  1  1 = drive pad
- Linear_Flash_data_i  in  DATA_W  data from pad

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, TURNAROUND.
- IDLE: if exactly one req is high, grant that port. If both are high, grant the port not served last. The last-served pointer resets to B, so A wins the first contention. On grant, capture addr, we and wdata, then go to SETUP.
- SETUP (1 cycle): ce_n = 0, address driven, oe_n = we_n = 1. For writes, data_oe = 1. Go to STROBE.
- STROBE: counter loads RD_WAIT or WR_WAIT and decrements.
  - Read: oe_n = 0. Linear_Flash_data_i is registered into the granted port's rdata on the last STROBE cycle.
  - Write: we_n = 0 and data is driven.
  - Go to HOLD when the counter reaches 1.
- HOLD (1 cycle): strobes high, ce_n = 0, address and write data still driven. The granted port's ack is high. Update the last-served pointer.
- TURNAROUND: ce_n = 1, data_oe = 0, for TURN cycles. With TURN = 0, go directly to IDLE.
- Only one strobe is ever low at a time. data_oe and oe_n are never active in the same cycle.
- A req that is still high in the cycle after its ack is treated as a new request.
- Dropping req before ack is illegal. The access still completes and ack still pulses.

## Timing
- All outputs are registered.
- Reset values: ce_n/oe_n/we_n = 1, data_oe = 0, address = 0, data_o = 0, acks = 0, rdata = 0, busy = 0, state = IDLE.
- Read latency: with grant at IDLE edge n, SETUP is cycle n+1, STROBE is cycles n+2 .. n+1+RD_WAIT, and ack is at cycle n+2+RD_WAIT. Writes follow the same pattern with WR_WAIT.
- Back-to-back throughput: one access per 3 + WAIT + TURN cycles.
- Reset asserted mid-access: strobes deassert and data_oe drops asynchronously. No ack is issued and the requester must reissue.

## Configuration
- LINEAR_FLASH_WR_EN defined: writes are performed as described above.
- LINEAR_FLASH_WR_EN undefined:
  - we_n is tied 1, data_oe is tied 0, and data_o is tied 0.
  - A write request follows IDLE -> SETUP -> HOLD, skipping STROBE. ack pulses 2 cycles after grant and rdata is unchanged.
  - Reads are unaffected.

## Test plan
- Single read, A, addr 0x12345, RD_WAIT = 4, flash model returns 0xA5 -> oe_n low for exactly 4 cycles; a_ack 6 cycles after grant; a_rdata = 0xA5; ce_n high for 1 TURN cycle.
- Single write, B, addr 0x7FFFF, data 0x3C, WR_WAIT = 3 -> we_n low for 3 cycles; data_oe high from SETUP through HOLD; pad carries 0x3C; b_ack once.
- A and B request reads continuously from reset -> grants alternate A, B, A, B; no port is granted twice in a row while the other is pending.
- Reset asserted during STROBE of a read -> oe_n and ce_n go high in the same cycle as reset, no ack; A reissues after reset and completes normally.
- TURN = 0 back-to-back reads -> a new SETUP follows HOLD after exactly 1 IDLE cycle; oe_n and data_oe never overlap (checked by assertion throughout).
- LINEAR_FLASH_WR_EN undefined, write from A -> we_n stays 1 and data_oe stays 0; a_ack 2 cycles after grant.
